hazard_controller: RTL and testbench
====================================

# hazard_controller

Parametrised pipeline hazard and trap controller; the next generation of the core's hazard unit. It generates per-stage stall/flush vectors for a STAGES-deep pipeline and prioritises exceptions, MRET and branch redirects. It runs a multi-cycle load-use interlock and a trap sequencer with a CSR-unit handshake. It sits beside the pipeline registers and drives their control inputs.

## Interface
- STAGES, 4: pipeline registers; index 0 = fetch/decode, STAGES-1 = memory/writeback; legal 3..8
- NUM_SRC, 2: source registers checked for load-use
- LOAD_LATENCY, 1: bubbles inserted per load-use hazard; legal 1..7
- CAUSE_W, 4: mcause width
- DRAIN_CYCLES, 1: post-trap fetch-flush cycles; legal 1..15

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset)
- excValid  in  STAGES  per-stage exception request (valid & illegal pre-qualified)
- excCause  in  STAGES*CAUSE_W  cause of stage i at [i*CAUSE_W +: CAUSE_W]
- mretSignal  in  1  MRET redirect
- branchValid  in  1  PC redirect
- stallControl  in  1  external global stall (memory wait)
- srcValid  in  1  decode/execute holds a valid instruction
- srcReg  in  NUM_SRC*5  its source register indices
- loadValid  in  1  execute/memory holds a valid load (WB_MEM)
- loadDest  in  5  that load's destination
- trapAck  in  1  CSR unit accepted the trap
- stall  out  STAGES  per-register stall
- flush  out  STAGES  per-register flush
- controlReset  out  1  one-cycle trap-entry pulse
- trapValid  out  1  trap pending for CSR unit
- mcause  out  CAUSE_W  registered cause
- busy  out  1  FSM not in RUN

## Operation
- FSM states: RUN, TRAP, DRAIN.
- RUN, event priority (highest first):
  - exceptions at index ≥2
  - mretSignal
  - exceptions at index 0..1
  - branchValid
- Among exceptions, the highest index (oldest) wins.
- Exception at stage i:
  - flush[min(i+1,STAGES-1):0]=1 and controlReset=1, same cycle
  - mcause<=excCause slice i, trapValid<=1
  - next state TRAP
- mretSignal or branchValid: flush[1:0]=1; no state change.
- TRAP: flush = all ones, trapValid=1, mcause held. trapAck=1 → trapValid<=0, drain counter<=DRAIN_CYCLES-1, next state DRAIN.
- DRAIN:
  - flush[0]=1; counter decrements each cycle.
  - Counter 0 → RUN.
  - Exceptions, mretSignal and branchValid are ignored in TRAP and DRAIN.
- Load-use (RUN only):
  - Hazard when loadValid & srcValid & any k with srcReg[k]!=0 and srcReg[k]==loadDest, while luCount==0.
  - Detection cycle: stall[1:0]=1, flush[2]=1; luCount<=LOAD_LATENCY-1.
  - While luCount>0: same outputs, decrement.
  - Total bubbles = LOAD_LATENCY.
- stallControl=1:
  - stall = all ones.
  - luCount and drain counter are frozen.
  - The load-use flush[2] is suppressed.
  - Exception entry is still taken.
- Flush dominates: stall[i] is forced 0 whenever flush[i]=1.
- An exception entry in RUN clears luCount to 0.

## Timing
- stall, flush and controlReset are combinational from inputs and state, in the same cycle.
- trapValid and mcause are registered: first valid one cycle after the exception.
- trapAck is sampled only in TRAP. It may arrive in the first TRAP cycle, giving the minimum TRAP→DRAIN latency of 1 cycle.
- Trap entry to RUN = 1 + ack wait + DRAIN_CYCLES cycles.
- Reset (reset=0 at an edge), effective even mid-trap or mid-interlock:
  - state RUN, luCount=0, drain counter=0
  - trapValid=0, mcause=0
- While reset=0: stall, flush and controlReset are 0; busy=0.
- Simultaneous events:
  - Exception and load-use hazard in the same cycle: the exception wins; no interlock starts.
  - Branch and load-use in the same cycle: flush[1:0]=1 wins over stall[1:0]. The bubble flush[2] is still asserted. luCount is not loaded.

## Configuration
- HAZARD_LOAD_USE_EN defined: load-use interlock present as above.
- Undefined:
  - srcValid, srcReg, loadValid and loadDest are ignored.
  - luCount logic is absent.
  - stall comes only from stallControl.
  - Intended for cores with memory-stage forwarding.

## Test plan
- Exception at index 3, excCause slice 3=4'h4, also index 1 with 4'h2:
  - flush=4'b1111 and controlReset=1 that cycle.
  - Next cycle trapValid=1, mcause=4'h4.
  - trapAck after 3 cycles → DRAIN 1 cycle with flush=4'b0001, then busy=0.
- Decode exception at index 1 (cause 4'hB) together with mretSignal:
  - MRET wins: flush=4'b0011, no trap.
  - Next cycle with mretSignal low: trap taken, flush=4'b0111, mcause=4'hB.
- LOAD_LATENCY=3, loadDest=5, srcReg={5,0}, all valid → 3 consecutive cycles of stall[1:0]=1, flush[2]=1, then clear.
- Same load-use with stallControl high on the second cycle: stall=4'b1111, flush=0, interlock stretched to 4 cycles total.
- srcReg={0,0}, loadDest=0 → no stall. Without HAZARD_LOAD_USE_EN, the scenario-3 stimulus gives no stall.
- reset=0 during TRAP → next cycle trapValid=0, mcause=0, busy=0, all outputs 0.

Source files
------------

// File: rtl/hazard_controller_if.sv
// hazard_controller_if
//   Bundles the pipeline-facing signals of the hazard/trap controller.
//   master : pipeline / CSR side (drives requests, consumes stall/flush/trap)
//   slave  : hazard_controller
// Requests : excValid, excCause, mretSignal, branchValid, stallControl,
//            srcValid, srcReg, loadValid, loadDest, trapAck
// Controls : stall, flush, controlReset, trapValid, mcause, busy
interface hazard_controller_if #(
  parameter int STAGES  = 4,
  parameter int NUM_SRC = 2,
  parameter int CAUSE_W = 4
);
  logic [STAGES-1:0]         excValid;
  logic [STAGES*CAUSE_W-1:0] excCause;
  logic                      mretSignal;
  logic                      branchValid;
  logic                      stallControl;
  logic                      srcValid;
  logic [NUM_SRC*5-1:0]      srcReg;
  logic                      loadValid;
  logic [4:0]                loadDest;
  logic                      trapAck;

  logic [STAGES-1:0]         stall;
  logic [STAGES-1:0]         flush;
  logic                      controlReset;
  logic                      trapValid;
  logic [CAUSE_W-1:0]        mcause;
  logic                      busy;

  modport master (
    output excValid, excCause, mretSignal, branchValid, stallControl,
           srcValid, srcReg, loadValid, loadDest, trapAck,
    input  stall, flush, controlReset, trapValid, mcause, busy
  );

  modport slave (
    input  excValid, excCause, mretSignal, branchValid, stallControl,
           srcValid, srcReg, loadValid, loadDest, trapAck,
    output stall, flush, controlReset, trapValid, mcause, busy
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline hazard and trap controller. Produces per-stage stall/flush
//   vectors, prioritises exceptions / MRET / branch redirects, runs a
//   load-use interlock and a RUN -> TRAP -> DRAIN trap sequencer that
//   hands the cause to the CSR unit (trapValid/mcause, trapAck).
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : hazard_controller_if.slave (requests in, stall/flush/trap out)
// Build option:
//   HAZARD_LOAD_USE_EN - when defined, the load-use interlock is built;
//   otherwise srcValid/srcReg/loadValid/loadDest are ignored.
module hazard_controller #(
  parameter int STAGES       = 4,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int CAUSE_W      = 4,
  parameter int DRAIN_CYCLES = 1
) (
  input logic               clock,
  input logic               reset,
  hazard_controller_if.slave bus
);

  typedef enum logic [1:0] {S_RUN, S_TRAP, S_DRAIN} state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_drain_count, w_drain_nxt;
  logic               r_trap_valid, w_tv_nxt;
  logic [CAUSE_W-1:0] r_mcause, w_cause_nxt;

  logic [STAGES-1:0]  w_stall, w_flush;
  logic               w_ctrl_rst;
  logic [3:0]         w_exc_idx, w_flush_lim;
  logic               w_exc_any, w_take, w_redirect;

`ifdef HAZARD_LOAD_USE_EN
  localparam logic [2:0] LU_INIT = 3'(LOAD_LATENCY - 1);
  logic [2:0] r_lu_count, w_lu_nxt;
  logic       w_lu_hazard, w_lu_match;

  always_comb begin
    w_lu_match = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (bus.srcReg[k*5 +: 5] != 5'd0 && bus.srcReg[k*5 +: 5] == bus.loadDest)
        w_lu_match = 1'b1;
    end
    w_lu_hazard = bus.loadValid & bus.srcValid & w_lu_match & (r_lu_count == 3'd0);
  end
`else
  logic w_unused_lu;
  assign w_unused_lu = ^{bus.srcValid, bus.srcReg, bus.loadValid, bus.loadDest};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_count;
    w_tv_nxt    = r_trap_valid;
    w_cause_nxt = r_mcause;
    w_stall     = '0;
    w_flush     = '0;
    w_ctrl_rst  = 1'b0;
`ifdef HAZARD_LOAD_USE_EN
    w_lu_nxt    = r_lu_count;
`endif

    // Highest-index (oldest) exception wins.
    w_exc_idx = '0;
    w_exc_any = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (bus.excValid[i]) begin
        w_exc_idx = 4'(i);
        w_exc_any = 1'b1;
      end
    end
    // Back-end exceptions outrank MRET; decode-side ones yield to it.
    w_take      = w_exc_any & ((w_exc_idx >= 4'd2) | ~bus.mretSignal);
    w_redirect  = bus.mretSignal | bus.branchValid;
    w_flush_lim = (w_exc_idx >= 4'(STAGES - 1)) ? 4'(STAGES - 1) : w_exc_idx + 4'd1;

    case (r_state)
      S_RUN: begin
        if (w_take) begin
          for (int unsigned j = 0; j < STAGES; j++) begin
            if (4'(j) <= w_flush_lim) w_flush[j] = 1'b1;
          end
          w_ctrl_rst  = 1'b1;
          w_tv_nxt    = 1'b1;
          w_cause_nxt = bus.excCause[int'(w_exc_idx)*CAUSE_W +: CAUSE_W];
          w_state_nxt = S_TRAP;
`ifdef HAZARD_LOAD_USE_EN
          w_lu_nxt    = '0;
`endif
        end else begin
          if (w_redirect) w_flush[1:0] = '1;
`ifdef HAZARD_LOAD_USE_EN
          // Bubble: hold fetch/decode, squash what enters execute.
          // A redirect in the detection cycle cancels the interlock.
          if (w_lu_hazard || r_lu_count != 3'd0) begin
            w_stall[1:0] = '1;
            if (!bus.stallControl) begin
              w_flush[2] = 1'b1;
              if (r_lu_count != 3'd0) w_lu_nxt = r_lu_count - 3'd1;
              else if (!w_redirect)   w_lu_nxt = LU_INIT;
            end
          end
`endif
        end
      end
      S_TRAP: begin
        w_flush = '1;
        if (bus.trapAck) begin
          w_tv_nxt    = 1'b0;
          w_drain_nxt = DRAIN_INIT;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_flush[0] = 1'b1;
        if (!bus.stallControl) begin
          if (r_drain_count == 4'd0) w_state_nxt = S_RUN;
          else                       w_drain_nxt = r_drain_count - 4'd1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase

    if (bus.stallControl) w_stall = '1;
    w_stall = w_stall & ~w_flush;

    if (!reset) begin
      w_stall    = '0;
      w_flush    = '0;
      w_ctrl_rst = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= S_RUN;
      r_drain_count <= '0;
      r_trap_valid  <= 1'b0;
      r_mcause      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_drain_count <= w_drain_nxt;
      r_trap_valid  <= w_tv_nxt;
      r_mcause      <= w_cause_nxt;
    end
  end

`ifdef HAZARD_LOAD_USE_EN
  always_ff @(posedge clock) begin
    if (!reset) r_lu_count <= '0;
    else        r_lu_count <= w_lu_nxt;
  end
`endif

  assign bus.stall        = w_stall;
  assign bus.flush        = w_flush;
  assign bus.controlReset = w_ctrl_rst;
  assign bus.trapValid    = r_trap_valid;
  assign bus.mcause       = r_mcause;
  assign bus.busy         = reset & (r_state != S_RUN);

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//   Directed scenarios followed by randomized traffic, all checked each
//   cycle against a behavioural model of the controller's rules.
module tb_hazard_controller;
  localparam int S  = 4;
  localparam int LL = 3;
  localparam int DC = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_controller_if #(.STAGES(S), .NUM_SRC(2), .CAUSE_W(4)) hif ();

  hazard_controller #(
    .STAGES(S), .NUM_SRC(2), .LOAD_LATENCY(LL), .CAUSE_W(4), .DRAIN_CYCLES(DC)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (hif)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: phase 0 = running, 1 = waiting for CSR ack, 2 = draining fetch.
  int m_phase = 0, m_lu = 0, m_drain = 0, m_tv = 0, m_cause = 0;
  int n_phase, n_lu, n_drain, n_tv, n_cause;
  int e_stall, e_flush, e_cr, e_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === 32'(exp)) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    int  oldest, hi;
    bit  take, redir, hz;
    n_phase = m_phase; n_lu = m_lu; n_drain = m_drain; n_tv = m_tv; n_cause = m_cause;
    e_stall = 0; e_flush = 0; e_cr = 0; e_busy = 0;
    hz = 1'b0;
    if (!rst_n) begin
      n_phase = 0; n_lu = 0; n_drain = 0; n_tv = 0; n_cause = 0;
      return;
    end
    e_busy = (m_phase != 0);
    if (m_phase == 0) begin
      oldest = -1;
      for (int i = 0; i < S; i++) if (hif.excValid[i]) oldest = i;
      take  = (oldest >= 2) || (oldest >= 0 && !hif.mretSignal);
      redir = hif.mretSignal || hif.branchValid;
      if (take) begin
        hi      = (oldest + 1 < S - 1) ? oldest + 1 : S - 1;
        e_flush = (1 << (hi + 1)) - 1;
        e_cr    = 1;
        n_tv    = 1;
        n_cause = int'((hif.excCause >> (4 * oldest)) & 16'hF);
        n_phase = 1;
        n_lu    = 0;
      end else begin
        if (redir) e_flush = 3;
`ifdef HAZARD_LOAD_USE_EN
        for (int k = 0; k < 2; k++) begin
          int r;
          r = int'((hif.srcReg >> (5 * k)) & 10'h1F);
          if (r != 0 && r == int'(hif.loadDest)) hz = 1'b1;
        end
        hz = hz && hif.loadValid && hif.srcValid;
        if (m_lu > 0 || hz) begin
          e_stall = 3;
          if (!hif.stallControl) begin
            e_flush = e_flush | 4;
            if (m_lu > 0)   n_lu = m_lu - 1;
            else if (!redir) n_lu = LL - 1;
          end
        end
`endif
      end
    end else if (m_phase == 1) begin
      e_flush = (1 << S) - 1;
      if (hif.trapAck) begin
        n_tv = 0; n_drain = DC - 1; n_phase = 2;
      end
    end else begin
      e_flush = 1;
      if (!hif.stallControl) begin
        if (m_drain == 0) n_phase = 0;
        else              n_drain = m_drain - 1;
      end
    end
    if (hif.stallControl) e_stall = (1 << S) - 1;
    e_stall = e_stall & ~e_flush;
  endtask

  task automatic eval_check();
    model_eval();
    @(negedge clk);
    chk("stall",        hif.stall,        e_stall);
    chk("flush",        hif.flush,        e_flush);
    chk("controlReset", hif.controlReset, e_cr);
    chk("busy",         hif.busy,         e_busy);
    chk("trapValid",    hif.trapValid,    m_tv);
    chk("mcause",       hif.mcause,       m_cause);
  endtask

  task automatic advance();
    @(posedge clk);
    m_phase = n_phase; m_lu = n_lu; m_drain = n_drain; m_tv = n_tv; m_cause = n_cause;
    #1;
  endtask

  task automatic step();
    eval_check();
    advance();
  endtask

  task automatic idle();
    hif.excValid = '0; hif.excCause = '0; hif.mretSignal = 1'b0;
    hif.branchValid = 1'b0; hif.stallControl = 1'b0; hif.srcValid = 1'b0;
    hif.srcReg = '0; hif.loadValid = 1'b0; hif.loadDest = '0; hif.trapAck = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    // Reset state
    eval_check();
    chk("rst_busy", hif.busy, 0);
    chk("rst_flush", hif.flush, 0);
    advance();
    step();
    rst_n = 1'b1;
    step();

    // Oldest exception (index 3) beats index 1
    hif.excValid = 4'b1010;
    hif.excCause = {4'h4, 4'h0, 4'h2, 4'h0};
    eval_check();
    chk("tp1_flush", hif.flush, 4'b1111);
    chk("tp1_cr", hif.controlReset, 1);
    advance();
    idle();
    eval_check();
    chk("tp1_tv", hif.trapValid, 1);
    chk("tp1_cause", hif.mcause, 4'h4);
    advance();
    step();
    hif.trapAck = 1'b1;
    step();
    hif.trapAck = 1'b0;
    eval_check();
    chk("tp1_drain_flush", hif.flush, 4'b0001);
    chk("tp1_drain_busy", hif.busy, 1);
    advance();
    eval_check();
    chk("tp1_run_busy", hif.busy, 0);
    advance();

    // MRET beats a decode exception, then the exception is taken
    hif.excValid = 4'b0010;
    hif.excCause = 16'h00B0;
    hif.mretSignal = 1'b1;
    eval_check();
    chk("tp2_mret_flush", hif.flush, 4'b0011);
    chk("tp2_mret_cr", hif.controlReset, 0);
    advance();
    hif.mretSignal = 1'b0;
    eval_check();
    chk("tp2_exc_flush", hif.flush, 4'b0111);
    advance();
    idle();
    hif.trapAck = 1'b1;
    eval_check();
    chk("tp2_cause", hif.mcause, 4'hB);
    advance();
    idle();
    step();
    step();

    // Load-use interlock, LOAD_LATENCY bubbles
    hif.srcValid = 1'b1; hif.srcReg = {5'd5, 5'd0};
    hif.loadValid = 1'b1; hif.loadDest = 5'd5;
    for (int c = 0; c < 4; c++) begin
      eval_check();
`ifdef HAZARD_LOAD_USE_EN
      chk("tp3_stall", hif.stall, (c < 3) ? 4'b0011 : 4'b0000);
      chk("tp3_flush", hif.flush, (c < 3) ? 4'b0100 : 4'b0000);
`else
      chk("tp3_stall", hif.stall, 0);
      chk("tp3_flush", hif.flush, 0);
`endif
      advance();
      hif.loadValid = 1'b0;
    end

    // Same interlock stretched by a global stall in its second cycle
    hif.loadValid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      hif.stallControl = (c == 1);
      eval_check();
      if (c == 1) begin
        chk("tp4_gstall", hif.stall, 4'b1111);
        chk("tp4_gflush", hif.flush, 0);
      end else begin
`ifdef HAZARD_LOAD_USE_EN
        chk("tp4_stall", hif.stall, (c < 4) ? 4'b0011 : 4'b0000);
`else
        chk("tp4_stall", hif.stall, 0);
`endif
      end
      advance();
      hif.loadValid = 1'b0;
    end
    idle();

    // x0 never creates a hazard
    hif.srcValid = 1'b1; hif.srcReg = '0; hif.loadValid = 1'b1; hif.loadDest = '0;
    eval_check();
    chk("tp5_stall", hif.stall, 0);
    advance();
    idle();
    step();

    // Reset while waiting in TRAP
    hif.excValid = 4'b0100; hif.excCause = 16'h0700;
    step();
    idle();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    eval_check();
    chk("tp6_tv", hif.trapValid, 0);
    chk("tp6_cause", hif.mcause, 0);
    chk("tp6_busy", hif.busy, 0);
    chk("tp6_flush", hif.flush, 0);
    advance();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst_n            = ($urandom_range(0, 79) != 0);
      hif.excValid     = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
      hif.excCause     = 16'($urandom);
      hif.mretSignal   = ($urandom_range(0, 7) == 0);
      hif.branchValid  = ($urandom_range(0, 6) == 0);
      hif.stallControl = ($urandom_range(0, 5) == 0);
      hif.srcValid     = 1'($urandom);
      hif.srcReg       = 10'($urandom_range(0, 3) | ($urandom_range(0, 3) << 5));
      hif.loadValid    = 1'($urandom);
      hif.loadDest     = 5'($urandom_range(0, 3));
      hif.trapAck      = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
